dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Multi-cycle data-memory stage for the single-cycle ARM processor. It sits directly downstream of the datapath and uses the datapath's OPResult as the byte address and WriteData as the store data. It returns ReadData to the datapath's result mux. The block owns a word-addressed RAM with a configurable access latency. It raises Stall so the processor holds its PC and register writes until the access completes.

## Interface
- DEPTH, 64: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-4.
- LATENCY, 2: access latency in cycles; must be >= 1.

- clk  in  1  processor clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- MemRead  in  1  load request from the controller.
- MemWrite  in  1  store request from the controller.
- Addr  in  32  byte address (datapath OPResult).
- WriteData  in  32  store data (datapath WriteData).
- ReadData  out  32  registered load data; holds until the next load completes.
- Stall  out  1  combinational; high means the processor must not advance PC or write registers.
- Fault  out  1  registered, sticky; set by an illegal request, cleared only by reset.

## Operation
- FSM states: IDLE, WAIT, DONE. A down-counter cnt (width clog2(LATENCY)+1) and capture registers (op, word index, data) support the FSM.
- **Request legality** is evaluated in IDLE only.
  - A request is any cycle with MemRead or MemWrite high.
  - A request is illegal if:
    - MemRead and MemWrite are both high, or
    - Addr[1:0] != 0, or
    - Addr[31:2] >= DEPTH.
  - An illegal request sets Fault at the next edge. It performs no access, keeps Stall=0, and the state stays IDLE.
- **IDLE with a legal request:**
  - Stall=1 in this cycle.
  - Capture op, Addr[31:2] and WriteData at the edge.
  - If LATENCY==1, go to DONE and commit at this edge.
  - Otherwise go to WAIT with cnt=LATENCY-2.
- **WAIT:**
  - Stall=1. Inputs are ignored.
  - If cnt==0, commit and go to DONE. Otherwise decrement cnt.
- **Commit:**
  - Store: mem[idx] <= captured data; ReadData is unchanged.
  - Load: ReadData <= mem[idx].
- **DONE:**
  - Stall=0. The processor completes the instruction this cycle; the same request is still present on the inputs.
  - Always go to IDLE and ignore the inputs, so the held request is not re-issued.
- **No request in IDLE:** Stall=0 and no state change.
- Consecutive memory instructions each start fresh in IDLE.
- **Reset:** state=IDLE, cnt=0, ReadData=0, Stall=0, Fault=0. RAM contents are not cleared.
- **Reset has priority over commit.** If reset is high on the committing edge, the store is discarded and ReadData goes to 0.

## Timing
- A legal access occupies LATENCY+1 cycles: cycles 0..LATENCY-1 with Stall=1, then cycle LATENCY (DONE) with Stall=0.
- The commit happens on the edge that ends cycle LATENCY-1.
- Load data is visible on ReadData throughout the DONE cycle.
- A load issued right after a store to the same word returns the new data, because the store has committed before the load's IDLE cycle.
- Stall rises in the same cycle the request appears; it is combinational from MemRead, MemWrite and Addr while in IDLE.
- Fault rises one cycle after the illegal request and remains 1 until reset.
- Input changes during WAIT or DONE have no effect on the access in flight.

## Test plan
- **Reset:** assert reset 2 cycles with garbage inputs -> ReadData=0, Stall=0, Fault=0, FSM in IDLE.
- **Store then load, LATENCY=3, DEPTH=64:**
  - Store 0xDEADBEEF to 0x10 -> Stall=1 for 3 cycles, then 0 for 1 cycle.
  - Load 0x10 -> ReadData=0xDEADBEEF in its 4th cycle; Stall pattern 1,1,1,0.
- **Input corruption, LATENCY=3:** load 0x10, then change Addr to 0x20 and raise MemWrite during WAIT -> ReadData=0xDEADBEEF; mem[8] is unchanged.
- **Illegal requests:**
  - Load 0x13 -> Stall stays 0, Fault=1 next cycle, no RAM change.
  - After reset, store to 0x100 -> Fault=1.
  - After reset, MemRead=MemWrite=1 -> Fault=1.
- **Reset mid-store, LATENCY=3:**
  - Setup: mem[8]=0x11111111.
  - Store 0x22222222 to 0x20 and assert reset on the commit edge.
  - Load 0x20 -> 0x11111111.
- **LATENCY=1 back-to-back:**
  - Store 0xA5A5A5A5 to 0x0, then immediately load 0x0.
  - Required: Stall 1,0,1,0; ReadData=0xA5A5A5A5 in the 4th cycle.
  - Each DONE cycle must not re-trigger an access.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Processor-to-data-memory bus: request, address and data in; load data,
// stall and fault back to the processor.
interface dmem_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        fault;

  modport master (
    output mem_read, mem_write, addr, write_data,
    input  read_data, stall, fault
  );

  modport slave (
    input  mem_read, mem_write, addr, write_data,
    output read_data, stall, fault
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory stage: word-addressed RAM with a fixed access
// latency. Stall holds the processor until the access completes; illegal
// requests raise a sticky fault instead of accessing the RAM.
//
// state  | meaning
// S_IDLE | waiting for a request; legality checked here only
// S_WAIT | access in flight, cnt counts down to the commit edge
// S_DONE | access complete, processor advances; held request ignored
module dmem_ctrl #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  dmem_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_store_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      data_q;
  logic [31:0]      read_data_q;
  logic             fault_q;
  logic [31:0]      mem [DEPTH];

  logic             req, illegal, legal_req, start;
  logic             commit, c_store;
  logic [IDX_W-1:0] c_idx;
  logic [31:0]      c_data;

  // Classify the current input request.
  always_comb begin
    req       = bus.mem_read | bus.mem_write;
    illegal   = req && ((bus.mem_read && bus.mem_write) ||
                        (bus.addr[1:0] != 2'b00) ||
                        ({2'b00, bus.addr[31:2]} >= 32'(DEPTH)));
    legal_req = req && !illegal;
    start     = (state == S_IDLE) && legal_req;
  end

  // Commit source: with single-cycle latency the commit happens on the
  // capture edge, so the live inputs are used instead of the capture regs.
  always_comb begin
    commit  = 1'b0;
    c_store = op_store_q;
    c_idx   = idx_q;
    c_data  = data_q;
    if (start && (LATENCY == 1)) begin
      commit  = 1'b1;
      c_store = bus.mem_write;
      c_idx   = bus.addr[IDX_W+1:2];
      c_data  = bus.write_data;
    end else if ((state == S_WAIT) && (cnt == '0)) begin
      commit = 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (legal_req) state_nxt = (LATENCY == 1) ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stall is combinational from the request while idle.
  always_comb begin
    bus.stall = start || (state == S_WAIT);
  end

  // State register and latency down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start)
        cnt <= CNT_LOAD;
      else if ((state == S_WAIT) && (cnt != '0))
        cnt <= cnt - 1'b1;
    end
  end

  // Capture the request so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (start) begin
      op_store_q <= bus.mem_write;
      idx_q      <= bus.addr[IDX_W+1:2];
      data_q     <= bus.write_data;
    end
  end

  // Load data and sticky fault; reset wins over a coincident commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (commit && !c_store)
        read_data_q <= mem[c_idx];
      if ((state == S_IDLE) && illegal)
        fault_q <= 1'b1;
    end
  end

  // RAM write port; contents survive reset but a store under reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_store)
      mem[c_idx] <= c_data;
  end

  assign bus.read_data = read_data_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance at LATENCY=3 and one at LATENCY=1,
// directed scenarios followed by randomized accesses against an
// array-based model of memory contents, load data and fault.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if if3 ();
  dmem_ctrl_if if1 ();

  dmem_ctrl #(.DEPTH(64), .LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
  dmem_ctrl #(.DEPTH(64), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  // sel=0 drives the LATENCY=3 instance, sel=1 the LATENCY=1 instance.
  logic        sel = 1'b0;
  logic        mr = 1'b0, mw = 1'b0;
  logic [31:0] ad = '0, wd = '0;

  assign if3.mem_read   = sel ? 1'b0 : mr;
  assign if3.mem_write  = sel ? 1'b0 : mw;
  assign if3.addr       = ad;
  assign if3.write_data = wd;
  assign if1.mem_read   = sel ? mr : 1'b0;
  assign if1.mem_write  = sel ? mw : 1'b0;
  assign if1.addr       = ad;
  assign if1.write_data = wd;

  logic        obs_stall, obs_fault;
  logic [31:0] obs_rd;
  assign obs_stall = sel ? if1.stall     : if3.stall;
  assign obs_fault = sel ? if1.fault     : if3.fault;
  assign obs_rd    = sel ? if1.read_data : if3.read_data;

  logic [31:0] m_mem [2][64];
  bit          m_val [2][64];
  logic [31:0] m_rd  [2];
  logic        m_fault [2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mr = 1'b0; mw = 1'b0; ad = $urandom; wd = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    mr = 1'($urandom); mw = 1'($urandom); ad = $urandom; wd = $urandom;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; mr = 1'b0; mw = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_rd[s] = '0;
      m_fault[s] = 1'b0;
    end
    @(negedge clk);
    check("rst_rd_l3",    if3.read_data, 32'h0);
    check("rst_stall_l3", 32'(if3.stall), 32'h0);
    check("rst_fault_l3", 32'(if3.fault), 32'h0);
    check("rst_rd_l1",    if1.read_data, 32'h0);
    check("rst_stall_l1", 32'(if1.stall), 32'h0);
    check("rst_fault_l1", 32'(if1.fault), 32'h0);
  endtask

  // One memory instruction. The request is held through its DONE cycle;
  // the task returns mid-way through DONE so the next call starts back-to-back.
  task automatic access(input bit s, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d, input bit corrupt);
    int lat;
    bit legal;
    int w;
    lat   = s ? 1 : 3;
    legal = (rd ^ wr) && (a[1:0] == 2'b00) && ((a >> 2) < 64);
    w     = int'(a[7:2]);
    @(posedge clk); #1;
    sel = s; mr = rd; mw = wr; ad = a; wd = d;
    if (!legal) begin
      @(negedge clk);
      check("illegal_stall", 32'(obs_stall), 32'h0);
      m_fault[s] = 1'b1;
      @(posedge clk); #1;
      mr = 1'b0; mw = 1'b0;
      @(negedge clk);
      check("fault_set", 32'(obs_fault), 32'h1);
      check("illegal_rd", obs_rd, m_rd[s]);
      return;
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check("busy_stall", 32'(obs_stall), 32'h1);
      if (k < lat - 1) begin
        @(posedge clk); #1;
        if (corrupt) begin
          ad = 32'($urandom_range(0, 63) * 4);
          mw = 1'b1;
          mr = 1'($urandom);
          wd = $urandom;
        end
      end
    end
    @(posedge clk);
    if (wr) begin
      m_mem[s][w] = d;
      m_val[s][w] = 1'b1;
    end else begin
      m_rd[s] = m_mem[s][w];
    end
    @(negedge clk);
    check("done_stall", 32'(obs_stall), 32'h0);
    check("done_rd",    obs_rd, m_rd[s]);
    check("done_fault", 32'(obs_fault), 32'(m_fault[s]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 64; i++) m_val[s][i] = 1'b0;
      m_rd[s] = '0;
      m_fault[s] = 1'b0;
    end

    do_reset();

    // Store then load, LATENCY=3.
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
    access(0, 1, 0, 32'h10, 32'h0, 0);

    // Input corruption during WAIT must not disturb the load or mem[8].
    access(0, 0, 1, 32'h20, 32'h12345678, 0);
    access(0, 1, 0, 32'h10, 32'h0, 1);
    access(0, 1, 0, 32'h20, 32'h0, 0);

    // Misaligned load: fault, no RAM change.
    access(0, 1, 0, 32'h13, 32'h0, 0);
    access(0, 1, 0, 32'h10, 32'h0, 0);

    do_reset();
    access(0, 0, 1, 32'h100, 32'hCAFEF00D, 0);
    do_reset();
    access(0, 1, 1, 32'h0, 32'h0, 0);
    do_reset();

    // Reset on the commit edge of a store discards it.
    access(0, 0, 1, 32'h20, 32'h11111111, 0);
    @(posedge clk); #1;
    sel = 1'b0; mr = 1'b0; mw = 1'b1; ad = 32'h20; wd = 32'h22222222;
    @(negedge clk);
    check("rst_store_stall", 32'(obs_stall), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mw = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_rd[s] = '0;
      m_fault[s] = 1'b0;
    end
    @(negedge clk);
    check("rst_commit_rd",    obs_rd, 32'h0);
    check("rst_commit_stall", 32'(obs_stall), 32'h0);
    access(0, 1, 0, 32'h20, 32'h0, 0);

    // LATENCY=1 back-to-back store and load.
    access(1, 0, 1, 32'h0, 32'hA5A5A5A5, 0);
    access(1, 1, 0, 32'h0, 32'h0, 0);
    go_idle();
    @(negedge clk);
    check("l1_idle_stall", 32'(obs_stall), 32'h0);
    check("l1_idle_rd",    obs_rd, 32'hA5A5A5A5);

    // Randomized accesses on both instances.
    for (int i = 0; i < 80; i++) begin
      bit s;
      int kind;
      int w;
      s    = 1'($urandom);
      kind = $urandom_range(0, 11);
      w    = $urandom_range(0, 63);
      if (kind <= 3 && m_val[s][w])
        access(s, 1, 0, 32'(w * 4), $urandom, kind == 0);
      else if (kind <= 8)
        access(s, 0, 1, 32'(w * 4), $urandom, kind == 4);
      else if (kind == 9)
        access(s, 1'($urandom), 1'b1, 32'(w * 4 + $urandom_range(1, 3)), $urandom, 0);
      else if (kind == 10)
        access(s, 1'b1, 1'b1, 32'(w * 4), $urandom, 0);
      else
        access(s, 1'b0, 1'b1, 32'($urandom_range(64, 4000) * 4), $urandom, 0);
    end

    // Read back every word written, through each instance.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 64; w++)
        if (m_val[s][w]) access(1'(s), 1, 0, 32'(w * 4), 32'h0, 0);

    go_idle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
